// File: rtl/pu_riscv_ex_sched.sv
// Execute-stage scheduler: arbitrates the single writeback port between the ALU,
// multiplier and divider, launches the multi-cycle units and watchdogs their latency.
module pu_riscv_ex_sched #(
  parameter int XLEN    = 64,
  parameter int MAX_LAT = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush,
  input  logic       id_bubble,
  input  logic [1:0] id_class,
  output logic       mul_start,
  input  logic       mul_done,
  output logic       div_start,
  input  logic       div_done,
  output logic       unit_kill,
  input  logic       wb_ready,
  output logic       wb_valid,
  output logic [1:0] wb_sel,
  output logic       ex_stall,
  output logic       sched_err
);

  localparam int CNTW = $clog2(MAX_LAT + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAX_LAT - 1);

  if (MAX_LAT < 2 || MAX_LAT > 255 || XLEN < 1) begin : g_param_check
    $error("pu_riscv_ex_sched: MAX_LAT must be 2..255 and XLEN positive");
  end

  typedef enum logic [1:0] {IDLE, BUSY_MUL, BUSY_DIV} state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            wb_valid_nxt, mul_start_nxt, div_start_nxt, sched_err_nxt;
  logic [1:0]      wb_sel_nxt;
  logic            issue;

  assign ex_stall  = (state != IDLE) | (wb_valid & ~wb_ready);
  assign issue     = (state == IDLE) & ~id_bubble & ~ex_stall & ~flush;
  assign unit_kill = flush & (state != IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    // An unaccepted result stays on the port; an accepted one drops unless reloaded.
    wb_valid_nxt  = wb_valid & ~wb_ready;
    wb_sel_nxt    = wb_sel;
    mul_start_nxt = 1'b0;
    div_start_nxt = 1'b0;
    sched_err_nxt = 1'b0;
    if (flush) begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      wb_valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            case (id_class)
              2'd0: begin
                wb_valid_nxt = 1'b1;
                wb_sel_nxt   = 2'd0;
              end
              2'd1: begin
                state_nxt     = BUSY_MUL;
                mul_start_nxt = 1'b1;
                cnt_nxt       = '0;
              end
              2'd2: begin
                state_nxt     = BUSY_DIV;
                div_start_nxt = 1'b1;
                cnt_nxt       = '0;
              end
              default: ;
            endcase
          end
        end
        BUSY_MUL: begin
          cnt_nxt = cnt + CNTW'(1);
          // Done is checked before the watchdog so a last-cycle result is not lost.
          if (mul_done) begin
            state_nxt    = IDLE;
            wb_valid_nxt = 1'b1;
            wb_sel_nxt   = 2'd1;
            cnt_nxt      = '0;
          end else if (cnt == LAST_CNT) begin
            state_nxt     = IDLE;
            sched_err_nxt = 1'b1;
            cnt_nxt       = '0;
          end
        end
        BUSY_DIV: begin
          cnt_nxt = cnt + CNTW'(1);
          if (div_done) begin
            state_nxt    = IDLE;
            wb_valid_nxt = 1'b1;
            wb_sel_nxt   = 2'd2;
            cnt_nxt      = '0;
          end else if (cnt == LAST_CNT) begin
            state_nxt     = IDLE;
            sched_err_nxt = 1'b1;
            cnt_nxt       = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      wb_valid  <= 1'b0;
      wb_sel    <= 2'd0;
      mul_start <= 1'b0;
      div_start <= 1'b0;
      sched_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wb_valid  <= wb_valid_nxt;
      wb_sel    <= wb_sel_nxt;
      mul_start <= mul_start_nxt;
      div_start <= div_start_nxt;
      sched_err <= sched_err_nxt;
    end
  end

endmodule
